// File: rtl/multi_timer_pkg.sv
// Shared constants for multi_timer: register map, CFG bit positions and channel limits.
// The optional per-channel pulse output is selected by MULTI_TIMER_PULSE_OUT_EN.
package multi_timer_pkg;

  localparam int MAX_CH = 8;

  // Global registers
  localparam logic [7:0] ADDR_PRESC  = 8'h00;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;

  // Channel window: channel n lives at CH_BASE + n*CH_STRIDE
  localparam logic [7:0] CH_BASE   = 8'h10;
  localparam logic [7:0] CH_STRIDE = 8'h10;
  localparam int         CH_SHIFT  = $clog2(CH_STRIDE);

  localparam logic [3:0] OFF_CFG    = 4'h0;
  localparam logic [3:0] OFF_RELOAD = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int CFG_EN_BIT  = 0;
  localparam int CFG_PER_BIT = 1;

  function automatic logic [31:0] cfg_word(input logic en, input logic per);
    logic [31:0] w;
    w              = '0;
    w[CFG_EN_BIT]  = en;
    w[CFG_PER_BIT] = per;
    return w;
  endfunction

endpackage

// File: rtl/multi_timer_chan.sv
// One down-counter channel: enable/periodic config, reload value, count and timeout detection.
// The timeout pulse is combinational and valid only in the cycle of the tick that causes it.
module timer_chan
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_wdata_i,
  input  logic             reload_we_i,
  input  logic [CNT_W-1:0] reload_wdata_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] reload_o,
  output logic             enable_o,
  output logic             periodic_o
);

  logic             enable_q;
  logic             periodic_q;
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] count_q;
  logic             start;
  logic             count_zero;

  assign count_zero = (count_q == '0);
  assign timeout_o  = tick_i && enable_q && count_zero;
  // Only a 0->1 transition of enable reloads; re-writing enable=1 leaves COUNT alone.
  assign start      = cfg_we_i && !enable_q && cfg_wdata_i[CFG_EN_BIT];

  // A CFG write overrides the one-shot auto-clear in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
    end else if (cfg_we_i) begin
      enable_q   <= cfg_wdata_i[CFG_EN_BIT];
      periodic_q <= cfg_wdata_i[CFG_PER_BIT];
    end else if (timeout_o && !periodic_q) begin
      enable_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reload_q <= '0;
    end else if (reload_we_i) begin
      reload_q <= reload_wdata_i;
    end
  end

  // start samples reload_q before any same-cycle RELOAD write lands.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= reload_q;
    end else if (tick_i && enable_q) begin
      if (count_zero) begin
        count_q <= periodic_q ? reload_q : '0;
      end else begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign count_o    = count_q;
  assign reload_o   = reload_q;
  assign enable_o   = enable_q;
  assign periodic_o = periodic_q;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH down-counter timers sharing one prescaler, with sticky W1C status and a masked level irq.
// Define MULTI_TIMER_PULSE_OUT_EN to add timeout_o, a registered one-cycle pulse per channel timeout.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_sel_i,
  input  logic              cfg_wr_i,
  input  logic [31:0]       cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic [31:0]       cfg_rdata_o,
  output logic              irq_o
`ifdef MULTI_TIMER_PULSE_OUT_EN
  ,
  output logic [NUM_CH-1:0] timeout_o
`endif
);

  logic [7:0]         addr;
  logic               wr_en;
  logic               ch_space;
  logic [7:0]         ch_rel;
  logic [3:0]         ch_idx;
  logic [3:0]         ch_off;

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt_q;
  logic               tick;
  logic               presc_we;
  logic               irq_en_we;
  logic [NUM_CH-1:0]  irq_en_q;
  logic [NUM_CH-1:0]  status_q;
  logic [NUM_CH-1:0]  w1c_mask;
  logic               irq_q;

  logic [NUM_CH-1:0]  ch_cfg_we;
  logic [NUM_CH-1:0]  ch_reload_we;
  logic [NUM_CH-1:0]  ch_timeout;
  logic [NUM_CH-1:0]  ch_en;
  logic [NUM_CH-1:0]  ch_per;
  logic [CNT_W-1:0]   ch_count  [NUM_CH];
  logic [CNT_W-1:0]   ch_reload [NUM_CH];

  logic               unused_bits;

  // Only the low address byte is decoded; upper write-data bits are dropped per field.
  assign unused_bits = ^{cfg_addr_i[31:8], cfg_wdata_i};

  assign addr     = cfg_addr_i[7:0];
  assign wr_en    = cfg_sel_i && cfg_wr_i;
  assign ch_space = (addr >= CH_BASE);
  assign ch_rel   = addr - CH_BASE;
  assign ch_idx   = 4'(ch_rel >> CH_SHIFT);
  assign ch_off   = ch_rel[CH_SHIFT-1:0];

  assign presc_we  = wr_en && !ch_space && (addr == ADDR_PRESC);
  assign irq_en_we = wr_en && !ch_space && (addr == ADDR_IRQ_EN);
  assign w1c_mask  = (wr_en && !ch_space && (addr == ADDR_STATUS)) ?
                     cfg_wdata_i[NUM_CH-1:0] : '0;

  // Prescaler: tick in the cycle presc_cnt reaches PRESC; a PRESC write restarts the count.
  assign tick = (presc_cnt_q == presc_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q <= '0;
    end else if (presc_we) begin
      presc_q <= cfg_wdata_i[PRESC_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_cnt_q <= '0;
    end else if (presc_we || tick) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_en_q <= '0;
    end else if (irq_en_we) begin
      irq_en_q <= cfg_wdata_i[NUM_CH-1:0];
    end
  end

  // A timeout in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | ch_timeout;
      irq_q    <= |(status_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_cfg_we[n]    = wr_en && ch_space && (ch_idx == 4'(n)) && (ch_off == OFF_CFG);
    assign ch_reload_we[n] = wr_en && ch_space && (ch_idx == 4'(n)) && (ch_off == OFF_RELOAD);

    timer_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .tick_i         (tick),
      .cfg_we_i       (ch_cfg_we[n]),
      .cfg_wdata_i    (cfg_wdata_i[1:0]),
      .reload_we_i    (ch_reload_we[n]),
      .reload_wdata_i (cfg_wdata_i[CNT_W-1:0]),
      .timeout_o      (ch_timeout[n]),
      .count_o        (ch_count[n]),
      .reload_o       (ch_reload[n]),
      .enable_o       (ch_en[n]),
      .periodic_o     (ch_per[n])
    );
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (!ch_space) begin
      case (addr)
        ADDR_PRESC:  cfg_rdata_o = 32'(presc_q);
        ADDR_IRQ_EN: cfg_rdata_o = 32'(irq_en_q);
        ADDR_STATUS: cfg_rdata_o = 32'(status_q);
        default:     cfg_rdata_o = '0;
      endcase
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == 4'(n)) begin
          case (ch_off)
            OFF_CFG:    cfg_rdata_o = cfg_word(ch_en[n], ch_per[n]);
            OFF_RELOAD: cfg_rdata_o = 32'(ch_reload[n]);
            OFF_COUNT:  cfg_rdata_o = 32'(ch_count[n]);
            default:    cfg_rdata_o = '0;
          endcase
        end
      end
    end
  end

`ifdef MULTI_TIMER_PULSE_OUT_EN
  logic [NUM_CH-1:0] timeout_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= ch_timeout;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule
